// File: rtl/snn_wta_pkg.sv
// rtl/snn_wta_pkg.sv - shared state type and width helpers for the WTA classifier
package snn_wta_pkg;

    typedef enum logic [1:0] {
        WTA_IDLE   = 2'd0,
        WTA_COUNT  = 2'd1,
        WTA_SEARCH = 2'd2,
        WTA_REPORT = 2'd3
    } wta_state_e;

    // Node index width; a single node still needs one bit to carry index 0
    function automatic int idx_width(input int num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

    // Step counter width, wide enough to hold WINDOW_LEN itself
    function automatic int step_width(input int window_len);
        return $clog2(window_len + 1);
    endfunction

    // All-ones value of a w-bit counter
    function automatic longint sat_max(input int w);
        return (longint'(1) << w) - 1;
    endfunction

endpackage

// File: rtl/wta_sat_counter.sv
// rtl/wta_sat_counter.sv - one saturating per-node spike counter
module wta_sat_counter
    import snn_wta_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over counting; the counter sticks at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (en_i && inc_i && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/spike_wta_classifier.sv
// rtl/spike_wta_classifier.sv - windowed winner-take-all spike classifier (optional WTA_LEADER_SPIKE_EN)
module spike_wta_classifier
    import snn_wta_pkg::*;
#(
    parameter  int NUM_NODES  = 4,
    parameter  int CNT_W      = 8,
    parameter  int WINDOW_LEN = 16,
    localparam int IDX_W      = idx_width(NUM_NODES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 step_i,
    input  logic [NUM_NODES-1:0] nodes_i,
    output logic                 busy_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [IDX_W-1:0]     winner_o,
    output logic [CNT_W-1:0]     winner_cnt_o,
    output logic                 spike_o
);

    localparam int                STEP_W    = step_width(WINDOW_LEN);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NODES - 1);

    wta_state_e        r_state;
    logic [STEP_W-1:0] r_step_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_best_idx;
    logic [CNT_W-1:0]  r_best_cnt;
    logic [IDX_W-1:0]  r_winner;
    logic [CNT_W-1:0]  r_winner_cnt;
    logic              r_busy;
    logic              r_valid;

    logic [CNT_W-1:0]  w_cnt [NUM_NODES];
    logic [CNT_W-1:0]  w_cur_cnt;
    logic              w_clear;
    logic              w_count_en;
    logic              w_take;

    // Abort blocks both the start clear and counting so counters stay as-is
    assign w_clear    = (r_state == WTA_IDLE) && start_i && !abort_i;
    assign w_count_en = (r_state == WTA_COUNT) && step_i && !abort_i;
    assign w_cur_cnt  = w_cnt[r_idx];
    // Strict compare keeps the earlier (lower) index on ties
    assign w_take     = (w_cur_cnt > r_best_cnt);

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
        wta_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (w_clear),
            .en_i    (w_count_en),
            .inc_i   (nodes_i[g]),
            .cnt_o   (w_cnt[g])
        );
    end

    // Window FSM: count steps, scan one node per cycle, hold result until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= WTA_IDLE;
            r_step_cnt   <= '0;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_cnt   <= '0;
            r_winner     <= '0;
            r_winner_cnt <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
        end else if (abort_i) begin
            r_state <= WTA_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                WTA_IDLE: begin
                    if (start_i) begin
                        r_state    <= WTA_COUNT;
                        r_step_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                WTA_COUNT: begin
                    if (step_i) begin
                        r_step_cnt <= r_step_cnt + STEP_W'(1);
                        if (r_step_cnt == LAST_STEP) begin
                            r_state    <= WTA_SEARCH;
                            r_idx      <= '0;
                            r_best_idx <= '0;
                            r_best_cnt <= '0;
                        end
                    end
                end
                WTA_SEARCH: begin
                    if (w_take) begin
                        r_best_idx <= r_idx;
                        r_best_cnt <= w_cur_cnt;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state      <= WTA_REPORT;
                        r_valid      <= 1'b1;
                        r_winner     <= w_take ? r_idx : r_best_idx;
                        r_winner_cnt <= w_take ? w_cur_cnt : r_best_cnt;
                    end
                end
                WTA_REPORT: begin
                    if (ready_i) begin
                        r_state <= WTA_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= WTA_IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign valid_o      = r_valid;
    assign winner_o     = r_winner;
    assign winner_cnt_o = r_winner_cnt;

`ifdef WTA_LEADER_SPIKE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [IDX_W-1:0] r_leader;
    logic [IDX_W-1:0] w_leader_nxt;
    logic             r_spike;

    // Arg-max over the counts as they will be after this step's increment
    always_comb begin : leader_search
        logic [CNT_W-1:0] v_post;
        logic [CNT_W-1:0] v_best;
        w_leader_nxt = '0;
        v_best       = '0;
        v_post       = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            v_post = (nodes_i[i] && (w_cnt[i] != CNT_MAX)) ? w_cnt[i] + CNT_W'(1) : w_cnt[i];
            if (v_post > v_best) begin
                v_best       = v_post;
                w_leader_nxt = IDX_W'(i);
            end
        end
    end

    // Echo the previous leader's input on step edges, then move the leader
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_leader <= '0;
            r_spike  <= 1'b0;
        end else if (w_clear) begin
            r_leader <= '0;
            r_spike  <= 1'b0;
        end else if (w_count_en) begin
            r_spike  <= nodes_i[r_leader];
            r_leader <= w_leader_nxt;
        end else begin
            r_spike  <= 1'b0;
        end
    end

    assign spike_o = r_spike;
`else
    assign spike_o = 1'b0;
`endif

endmodule

// File: tb/tb_spike_wta_classifier.sv
// tb/tb_spike_wta_classifier.sv - directed self-checking bench for spike_wta_classifier
module tb_spike_wta_classifier;

    localparam int NN = 4;
    localparam int CW = 3;
    localparam int WL = 8;
    localparam int CMAX = 7;
`ifdef WTA_LEADER_SPIKE_EN
    localparam bit LEADER_EN = 1'b1;
`else
    localparam bit LEADER_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          step = 1'b0;
    logic          ready = 1'b0;
    logic [NN-1:0] nodes = '0;
    logic          busy;
    logic          valid;
    logic          spike;
    logic [1:0]    winner;
    logic [CW-1:0] wcnt;

    always #5 clk = ~clk;

    spike_wta_classifier #(.NUM_NODES(NN), .CNT_W(CW), .WINDOW_LEN(WL)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .step_i       (step),
        .nodes_i      (nodes),
        .busy_o       (busy),
        .valid_o      (valid),
        .ready_i      (ready),
        .winner_o     (winner),
        .winner_cnt_o (wcnt),
        .spike_o      (spike)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 counting, 2 searching, 3 reporting
    int m_mode = 0;
    int m_cnt [NN];
    int m_steps = 0;
    int m_left = 0;
    int m_win = 0;
    int m_wcnt = 0;
    int m_leader = 0;
    int m_busy = 0;
    int m_valid = 0;
    int m_spike = 0;

    function automatic int best_index();
        int b = 0;
        for (int i = 1; i < NN; i++)
            if (m_cnt[i] > m_cnt[b]) b = i;
        return b;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_mode = 0; m_steps = 0; m_left = 0; m_win = 0; m_wcnt = 0;
            m_leader = 0; m_busy = 0; m_valid = 0; m_spike = 0;
            for (int i = 0; i < NN; i++) m_cnt[i] = 0;
            return;
        end
        if (abort) begin
            m_mode = 0; m_busy = 0; m_valid = 0; m_spike = 0;
            return;
        end
        m_spike = 0;
        case (m_mode)
            0: if (start) begin
                for (int i = 0; i < NN; i++) m_cnt[i] = 0;
                m_mode = 1; m_busy = 1; m_steps = 0; m_leader = 0;
            end
            1: if (step) begin
                m_spike = LEADER_EN ? int'(nodes[m_leader]) : 0;
                for (int i = 0; i < NN; i++)
                    if (nodes[i] && m_cnt[i] < CMAX) m_cnt[i]++;
                m_leader = best_index();
                m_steps++;
                if (m_steps == WL) begin
                    m_mode = 2;
                    m_left = NN;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 3; m_valid = 1;
                    m_win = best_index();
                    m_wcnt = m_cnt[m_win];
                end
            end
            default: if (ready) begin
                m_mode = 0; m_valid = 0; m_busy = 0;
            end
        endcase
    endtask

    // Every-cycle comparison of all outputs against the model
    initial begin
        for (int i = 0; i < NN; i++) m_cnt[i] = 0;
        forever begin
            @(posedge clk);
            model_update();
            #1;
            chk("cyc_busy",   int'(busy),   m_busy);
            chk("cyc_valid",  int'(valid),  m_valid);
            chk("cyc_winner", int'(winner), m_win);
            chk("cyc_wcnt",   int'(wcnt),   m_wcnt);
            chk("cyc_spike",  int'(spike),  m_spike);
        end
    end

    // Node a spikes on the first a_n steps, node b on the last b_n steps
    function automatic logic [31:0] pat_fn(input int a, input int a_n, input int b, input int b_n);
        logic [31:0] p = '0;
        for (int k = 0; k < WL; k++) begin
            if (k < a_n) p[4*k + a] = 1'b1;
            if (k >= WL - b_n) p[4*k + b] = 1'b1;
        end
        return p;
    endfunction

    task automatic run_window(input logic [31:0] pat, input int probe, input int probe_exp);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < WL; k++) begin
            nodes = pat[4*k +: 4];
            step  = 1'b1;
            @(posedge clk); #1;
            if (k == probe) chk("leader_spike", int'(spike), probe_exp);
            @(negedge clk);
        end
        step  = 1'b0;
        nodes = '0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic handshake();
        @(negedge clk); ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_busy",  int'(busy),  0);
        chk("hs_valid", int'(valid), 0);
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic full_window(input string tag, input logic [31:0] pat, input int ew, input int ec);
        int edges;
        run_window(pat, -1, 0);
        wait_valid(edges);
        chk({tag, "_latency"}, edges, NN);
        chk({tag, "_valid"},  int'(valid),  1);
        chk({tag, "_winner"}, int'(winner), ew);
        chk({tag, "_count"},  int'(wcnt),   ec);
        chk({tag, "_model"},  m_win * 16 + m_wcnt, ew * 16 + ec);
        handshake();
    endtask

    initial begin
        int edges;
        #1;
        chk("rst_busy",   int'(busy),   0);
        chk("rst_valid",  int'(valid),  0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_wcnt",   int'(wcnt),   0);
        chk("rst_spike",  int'(spike),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        full_window("clear_win", pat_fn(2, 5, 1, 3), 2, 5);
        full_window("tie_low",   pat_fn(1, 4, 3, 4), 1, 4);
        full_window("no_spike",  32'h0,              0, 0);
        full_window("saturate",  pat_fn(0, 8, 0, 0), 0, 7);

        // Back-pressure: result held for five cycles, start ignored meanwhile
        run_window(pat_fn(1, 3, 3, 6), -1, 0);
        wait_valid(edges);
        chk("bp_latency", edges, NN);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); start = (i == 2); ready = 1'b0;
            @(posedge clk); #1;
            chk("bp_valid",  int'(valid),  1);
            chk("bp_busy",   int'(busy),   1);
            chk("bp_winner", int'(winner), 3);
            chk("bp_count",  int'(wcnt),   6);
        end
        @(negedge clk); start = 1'b0;
        handshake();

        // Node3 leads from the first step; step 3 has node3 high
        run_window(32'h0000_8188, 3, LEADER_EN ? 1 : 0);
        wait_valid(edges);
        chk("lead_winner", int'(winner), 3);
        chk("lead_count",  int'(wcnt),   3);
        handshake();

        // Asynchronous reset in the middle of counting
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; nodes = 4'b0100; step = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; step = 1'b0; nodes = '0;
        #1;
        chk("arst_busy",   int'(busy),   0);
        chk("arst_valid",  int'(valid),  0);
        chk("arst_winner", int'(winner), 0);
        chk("arst_wcnt",   int'(wcnt),   0);
        chk("arst_spike",  int'(spike),  0);
        @(negedge clk); rst_n = 1'b1;

        // Abort during the search phase
        run_window(pat_fn(2, 2, 0, 0), -1, 0);
        @(posedge clk); #1;
        chk("abort_pre_busy", int'(busy), 1);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",  int'(busy),  0);
        chk("abort_valid", int'(valid), 0);
        @(negedge clk); abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", int'(valid), 0);
        end

        // Recovery: a normal window after the abort
        full_window("recover", pat_fn(3, 2, 1, 1), 3, 2);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/spike_wta_classifier.md
# spike_wta_classifier

Windowed winner-take-all classifier for the spiking output layer. It counts per-node spikes over a fixed number of time steps, then performs a sequential arg-max search. It reports the winning node index and count through a valid/ready handshake. It sits after the output-neuron array and replaces the per-cycle winner selection with a bounded-area, saturating, back-pressurable result.

## Interface
- NUM_NODES, 4, number of output nodes (≥1)
- CNT_W, 8, per-node spike counter width (≥1)
- WINDOW_LEN, 16, time steps per classification window (≥1)
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- start_i  in  1  begin a window (accepted only in IDLE)
- abort_i  in  1  synchronous abort, highest priority after reset
- step_i  in  1  time-step strobe; nodes_i sampled when high
- nodes_i  in  NUM_NODES  spike vector, bit i = node i
- busy_o  out  1  high in COUNT, SEARCH, REPORT
- valid_o  out  1  result valid
- ready_i  in  1  result consumer ready
- winner_o  out  IDX_W  winning node index
- winner_cnt_o  out  CNT_W  winning node's count
- spike_o  out  1  registered spike of running leader (see Configuration)

## Operation
- IDX_W = max(1, $clog2(NUM_NODES)); STEP_W = $clog2(WINDOW_LEN+1).
- States: IDLE, COUNT, SEARCH, REPORT.
- IDLE → COUNT on start_i. All node counters and step counter cleared on that edge.
- COUNT: each edge with step_i=1, cnt[i] += nodes_i[i], saturating at 2^CNT_W−1; step counter +1. On the edge sampling the WINDOW_LEN-th step → SEARCH, idx=0, best_cnt=0, best_idx=0.
- SEARCH: one node per cycle, idx 0..NUM_NODES−1. Replace best only if cnt[idx] > best_cnt (strict, so the lowest index wins ties). After idx=NUM_NODES−1 → REPORT.
- REPORT: valid_o=1. winner_o/winner_cnt_o hold stable until valid_o && ready_i, then → IDLE.
- All counts zero → winner_o=0, winner_cnt_o=0, still reported.
- abort_i=1 in any state → IDLE on next edge, valid_o dropped, counters left as-is. Overrides start_i, step_i, handshake.
- start_i outside IDLE ignored; step_i outside COUNT ignored.
- Reset: all state async to IDLE; busy_o, valid_o, winner_o, winner_cnt_o, spike_o = 0; counters = 0.

## Timing
- All outputs registered.
- valid_o asserts NUM_NODES edges after the edge sampling the last step.
- busy_o high from the edge after start_i until the handshake or abort edge.
- The handshake completes in the same cycle ready_i is seen. The minimum gap between windows is one IDLE cycle.
- Non-step cycles inside COUNT stretch the window; no timeout.

## Configuration
- WTA_LEADER_SPIKE_EN defined:
  - During COUNT, leader_q = arg-max of post-increment counts (lowest index on tie), updated on each step edge.
  - spike_o <= nodes_i[leader_q] on step edges and 0 otherwise. leader_q uses the value before that edge's update.
  - leader_q cleared on start.
- Undefined: spike_o tied 0, no comparator tree synthesised.

## Structure
- Package snn_wta_pkg:
  - state enum wta_state_e
  - width helper functions (IDX_W, STEP_W)
  - saturation-max constant function
- Sub-module wta_sat_counter: one CNT_W saturating counter with clear/enable/inc. Instantiated NUM_NODES times in a generate loop.

## Test plan
Bench uses NUM_NODES=4, CNT_W=3, WINDOW_LEN=8.
- Window with node2 spiking on 5 steps and node1 on 3 → winner_o=2, winner_cnt_o=5, valid_o 4 edges after the last step.
- Node1 and node3 each spiking 4 times → winner_o=1, winner_cnt_o=4 (tie to lowest index).
- No spikes for 8 steps → winner_o=0, winner_cnt_o=0, valid_o=1.
- Node0 spiking every step (8) → winner_cnt_o=7 (saturated), winner_o=0.
- ready_i low for 5 cycles in REPORT with start_i pulsed → outputs stable, start ignored. ready_i high → IDLE next edge, busy_o=0.
- rst_ni low mid-COUNT → all outputs 0 immediately. abort_i mid-SEARCH → IDLE next edge, valid_o never asserts.
- With WTA_LEADER_SPIKE_EN, node3 leading after step 2 → spike_o mirrors nodes_i[3] one edge later on step cycles.
